// File: rtl/burst_ram_pkg.sv
// Shared definitions for the BurstRAM two-requester arbiter: command codes,
// arbiter state encoding and the default burst length.
package burst_ram_pkg;

  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;

  localparam int unsigned BURST_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_WRITE,
    ARB_READ
  } arb_state_t;

endpackage

// File: rtl/burst_ram_arbiter_picker.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not served last.
module burst_ram_arbiter_picker (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one BurstRAM between two burst masters, holding the grant for a whole
// burst. Define BURST_RAM_ARBITER_BACK_TO_BACK_EN to re-arbitrate at burst end.
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned BURST_COUNT    = BURST_COUNT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req,
  input  logic                      m0_cmd,
  input  logic                      m0_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] m0_addr,
  input  logic [63:0]               m0_wr_data,
  input  logic [7:0]                m0_data_mask,
  output logic [63:0]               m0_rd_data,
  output logic                      m0_rd_data_ready,
  output logic                      m0_busy,
  input  logic                      m1_req,
  input  logic                      m1_cmd,
  input  logic                      m1_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] m1_addr,
  input  logic [63:0]               m1_wr_data,
  input  logic [7:0]                m1_data_mask,
  output logic [63:0]               m1_rd_data,
  output logic                      m1_rd_data_ready,
  output logic                      m1_busy,
  output logic                      br_cmd,
  output logic                      br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]               br_wr_data,
  output logic [7:0]                br_data_mask,
  input  logic [63:0]               br_rd_data,
  input  logic                      br_rd_data_ready,
  input  logic                      br_busy
);

  localparam int unsigned BEAT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

  arb_state_t        state;
  logic              owner;
  logic              last;
  logic [BEAT_W-1:0] beat;

  logic own_req;
  logic own_cmd;
  logic own_cmd_en;
  logic owner_ready;
  logic burst_done;
  logic pick_last;
  logic pick_valid;
  logic pick_winner;

  always_comb begin
    own_req      = owner ? m1_req       : m0_req;
    own_cmd      = owner ? m1_cmd       : m0_cmd;
    own_cmd_en   = owner ? m1_cmd_en    : m0_cmd_en;
    br_cmd       = own_cmd;
    br_addr      = owner ? m1_addr      : m0_addr;
    br_wr_data   = owner ? m1_wr_data   : m0_wr_data;
    br_data_mask = owner ? m1_data_mask : m0_data_mask;
    br_cmd_en    = (state == ARB_GRANT) && own_cmd_en && !br_busy;

    owner_ready = (state == ARB_GRANT) && !br_busy;
    m0_busy     = !(owner_ready && !owner);
    m1_busy     = !(owner_ready && owner);

    m0_rd_data       = br_rd_data;
    m1_rd_data       = br_rd_data;
    m0_rd_data_ready = br_rd_data_ready && (state == ARB_READ) && !owner;
    m1_rd_data_ready = br_rd_data_ready && (state == ARB_READ) && owner;

    burst_done = (beat == LAST_BEAT) &&
                 ((state == ARB_WRITE) || ((state == ARB_READ) && br_rd_data_ready));
  end

  // Outside IDLE the picker only matters at burst end, where the owner is
  // about to become the new `last`, so it is fed directly.
`ifdef BURST_RAM_ARBITER_BACK_TO_BACK_EN
  always_comb pick_last = (state == ARB_IDLE) ? last : owner;
`else
  always_comb pick_last = last;
`endif

  burst_ram_arbiter_picker u_picker (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (pick_last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      beat  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid && !br_busy) begin
            owner <= pick_winner;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (own_cmd_en && !br_busy) begin
            if (own_cmd == BR_CMD_WRITE) begin
              state <= ARB_WRITE;
              beat  <= BEAT_W'(1);
            end else begin
              state <= ARB_READ;
              beat  <= '0;
            end
          end else if (!own_req) begin
            state <= ARB_IDLE;
            last  <= owner;
          end
        end
        ARB_WRITE: beat <= beat + BEAT_W'(1);
        ARB_READ: begin
          if (br_rd_data_ready) beat <= beat + BEAT_W'(1);
        end
        default: state <= ARB_IDLE;
      endcase

      if (burst_done) begin
        last <= owner;
        beat <= '0;
`ifdef BURST_RAM_ARBITER_BACK_TO_BACK_EN
        if (pick_valid) begin
          owner <= pick_winner;
          state <= ARB_GRANT;
        end else begin
          state <= ARB_IDLE;
        end
`else
        state <= ARB_IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Randomised scoreboard bench for burst_ram_arbiter with a behavioural BurstRAM
// responder and a flat reference memory holding what each master intended.
module tb_burst_ram_arbiter;

  localparam int BC = 4;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    req, cmd, cmd_en, busy, rdy;
  logic [DW-1:0] addr  [2];
  logic [63:0]   wdata [2];
  logic [7:0]    mask  [2];
  logic [63:0]   rdata [2];

  logic          br_cmd, br_cmd_en;
  logic [DW-1:0] br_addr;
  logic [63:0]   br_wr_data;
  logic [7:0]    br_data_mask;
  logic [63:0]   br_rd_data;
  logic          br_rd_data_ready, br_busy;

  burst_ram_arbiter #(.DEPTH_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_cmd(cmd[0]), .m0_cmd_en(cmd_en[0]), .m0_addr(addr[0]),
    .m0_wr_data(wdata[0]), .m0_data_mask(mask[0]), .m0_rd_data(rdata[0]),
    .m0_rd_data_ready(rdy[0]), .m0_busy(busy[0]),
    .m1_req(req[1]), .m1_cmd(cmd[1]), .m1_cmd_en(cmd_en[1]), .m1_addr(addr[1]),
    .m1_wr_data(wdata[1]), .m1_data_mask(mask[1]), .m1_rd_data(rdata[1]),
    .m1_rd_data_ready(rdy[1]), .m1_busy(busy[1]),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_ready(br_rd_data_ready), .br_busy(br_busy)
  );

  typedef struct {
    int            who;
    logic          wr;
    logic [DW-1:0] a;
    logic [7:0]    m;
    logic [63:0]   d0;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] ref_mem [16];
  logic [63:0] ram [16];

  int n_checks = 0;
  int n_pass   = 0;
  int beats0   = 0;
  int beats1   = 0;
  bit alt_chk  = 1'b0;
  bit have_prev = 1'b0;
  int prev_who = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [4*64-1:0] rand_wd();
    logic [4*64-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // BurstRAM model: command/write capture
  logic [DW-1:0] wbase, rbase;
  int wcnt = 0;
  int rd_left = 0;
  int rd_idx = 0;

  always @(negedge clk) begin
    if (rst) begin
      wcnt    = 0;
      rd_left = 0;
    end else if (br_cmd_en) begin
      if (br_cmd) begin
        ram[br_addr] = br_wr_data;
        wbase = br_addr;
        wcnt  = 1;
      end else begin
        rbase   = br_addr;
        rd_idx  = 0;
        rd_left = BC;
      end
    end else if (wcnt != 0) begin
      ram[DW'(int'(wbase) + wcnt)] = br_wr_data;
      wcnt = (wcnt == BC - 1) ? 0 : wcnt + 1;
    end
  end

  // BurstRAM model: read beats with random gaps
  initial begin
    br_rd_data_ready = 1'b0;
    br_rd_data = '0;
    forever begin
      @(posedge clk); #2;
      br_rd_data_ready = 1'b0;
      if (rst) rd_left = 0;
      else if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
        br_rd_data = ram[DW'(int'(rbase) + rd_idx)];
        br_rd_data_ready = 1'b1;
        rd_idx++;
        rd_left--;
      end
    end
  end

  // Monitor: commands and read beats against the scoreboard
  cmd_t        mon_e;
  logic [63:0] mon_x;
  always @(negedge clk) begin
    if (br_cmd_en) begin
      if (cmd_q.size() == 0) chk(1'b0, "spurious_br_cmd_en", 64'(br_addr), 64'(0));
      else begin
        mon_e = cmd_q.pop_front();
        chk(br_cmd == mon_e.wr && br_addr == mon_e.a && br_data_mask == mon_e.m, "br_cmd_fields",
            64'({br_cmd, br_data_mask, br_addr}), 64'({mon_e.wr, mon_e.m, mon_e.a}));
        if (mon_e.wr) chk(br_wr_data == mon_e.d0, "br_wr_beat0", br_wr_data, mon_e.d0);
        if (alt_chk) begin
          if (have_prev) chk(mon_e.who != prev_who, "grant_alternation", 64'(mon_e.who), 64'(1 - prev_who));
          prev_who = mon_e.who;
          have_prev = 1'b1;
        end
      end
    end
    if (rdy[0] && rdy[1]) chk(1'b0, "both_rd_ready", 64'(rdy), 64'(0));
    if (rdy[0]) begin
      if (exp_q0.size() == 0) chk(1'b0, "m0_unexpected_beat", rdata[0], 64'(0));
      else begin
        mon_x = exp_q0.pop_front();
        chk(rdata[0] == mon_x, "m0_rd_data", rdata[0], mon_x);
      end
      beats0++;
    end
    if (rdy[1]) begin
      if (exp_q1.size() == 0) chk(1'b0, "m1_unexpected_beat", rdata[1], 64'(0));
      else begin
        mon_x = exp_q1.pop_front();
        chk(rdata[1] == mon_x, "m1_rd_data", rdata[1], mon_x);
      end
      beats1++;
    end
  end

  task automatic master_burst(input int n, input bit wr, input logic [DW-1:0] a,
                              input logic [4*64-1:0] wd);
    int   waited;
    cmd_t e;
    @(posedge clk); #1;
    req[n] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (busy[n] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (busy[n]) begin
      chk(1'b0, "grant_timeout", 64'(n), 64'(0));
      req[n] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.who = n; e.wr = wr; e.a = a; e.m = 8'($urandom); e.d0 = wd[63:0];
    cmd[n] = wr; addr[n] = a; mask[n] = e.m; wdata[n] = wd[63:0]; cmd_en[n] = 1'b1;
    cmd_q.push_back(e);
    for (int b = 0; b < BC; b++) begin
      if (wr) ref_mem[DW'(int'(a) + b)] = wd[b*64 +: 64];
      else if (n == 0) exp_q0.push_back(ref_mem[DW'(int'(a) + b)]);
      else exp_q1.push_back(ref_mem[DW'(int'(a) + b)]);
    end
    @(posedge clk); #1;
    cmd_en[n] = 1'b0;
    req[n] = 1'b0;
    if (wr) begin
      for (int b = 1; b < BC; b++) begin
        if (b > 1) begin @(posedge clk); #1; end
        wdata[n] = wd[b*64 +: 64];
      end
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk(exp_q0.size() == 0 && exp_q1.size() == 0, "read_drain",
        64'(exp_q0.size() + exp_q1.size()), 64'(0));
    chk(cmd_q.size() == 0, "cmd_queue_empty", 64'(cmd_q.size()), 64'(0));
    repeat (3) @(posedge clk);
  endtask

  task automatic random_master(input int n, input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      master_burst(n, 1'($urandom), DW'($urandom), rand_wd());
    end
  endtask

  int w;
  int b0_snap, b1_snap;

  initial begin
    rst = 1'b1; br_busy = 1'b1;
    req = '0; cmd = '0; cmd_en = '0;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; mask[i] = '0; end
    for (int i = 0; i < 16; i++) begin ram[i] = '0; ref_mem[i] = '0; end

    // Reset state, then br_busy held after release
    @(negedge clk);
    chk(busy == 2'b11, "reset_busy", 64'(busy), 64'(3));
    chk(!br_cmd_en, "reset_br_cmd_en", 64'(br_cmd_en), 64'(0));
    chk(rdy == 2'b00, "reset_rd_ready", 64'(rdy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    req[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(busy == 2'b11, "br_busy_hold", 64'(busy), 64'(3));
    end
    @(posedge clk); #1;
    br_busy = 1'b0;
    @(negedge clk);
    chk(busy[0], "grant_latency_n", 64'(busy[0]), 64'(1));
    @(negedge clk);
    chk(busy == 2'b10, "grant_latency_n1", 64'(busy), 64'(2));

    // m0 writes addr 2, m1 reads it back
    b0_snap = beats0; b1_snap = beats1;
    master_burst(0, 1'b1, DW'(2), {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    master_burst(1, 1'b0, DW'(2), '0);
    wait_drain();
    chk(beats1 - b1_snap == BC, "m1_beat_count", 64'(beats1 - b1_snap), 64'(BC));
    chk(beats0 == b0_snap, "m0_no_beats", 64'(beats0 - b0_snap), 64'(0));

    // Both requesting continuously: grants alternate
    alt_chk = 1'b1; have_prev = 1'b0;
    fork
      for (int i = 0; i < 3; i++) master_burst(0, 1'b0, DW'($urandom), '0);
      for (int i = 0; i < 3; i++) master_burst(1, 1'b0, DW'($urandom), '0);
    join
    wait_drain();
    alt_chk = 1'b0;

    // m1 granted, drops req without a command; m0 follows two cycles later
    @(posedge clk); #1;
    req[1] = 1'b1;
    w = 0;
    @(negedge clk);
    while (busy[1] && w < 50) begin @(negedge clk); w++; end
    chk(!busy[1], "m1_grant", 64'(busy[1]), 64'(0));
    @(posedge clk); #1;
    req[1] = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    chk(busy[0], "drop_cycle0", 64'(busy[0]), 64'(1));
    @(negedge clk);
    chk(busy[0], "drop_cycle1", 64'(busy[0]), 64'(1));
    @(negedge clk);
    chk(busy == 2'b10, "drop_cycle2", 64'(busy), 64'(2));
    master_burst(0, 1'b0, DW'($urandom), '0);
    wait_drain();

    // Reset during read beat 2
    b1_snap = beats1;
    master_burst(1, 1'b0, DW'($urandom), '0);
    w = 0;
    while (beats1 < b1_snap + 2 && w < 100) begin @(negedge clk); w++; end
    chk(beats1 == b1_snap + 2, "pre_reset_beats", 64'(beats1 - b1_snap), 64'(2));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(busy == 2'b11, "mid_burst_reset_busy", 64'(busy), 64'(3));
    chk(rdy == 2'b00, "mid_burst_reset_rdy", 64'(rdy), 64'(0));
    exp_q1.delete();
    @(posedge clk); #1;
    req = 2'b11;
    w = 0;
    @(negedge clk);
    while (busy == 2'b11 && w < 50) begin @(negedge clk); w++; end
    chk(busy == 2'b10, "tie_after_reset", 64'(busy), 64'(2));
    fork
      master_burst(0, 1'b0, DW'($urandom), '0);
      master_burst(1, 1'b0, DW'($urandom), '0);
    join
    wait_drain();

    // m0 write then m1 write: spacing between bursts
    fork
      master_burst(0, 1'b1, DW'($urandom), rand_wd());
      begin
        int wb = 0;
        @(negedge clk);
        while (busy[0] && wb < 50) begin @(negedge clk); wb++; end
        master_burst(1, 1'b1, DW'($urandom), rand_wd());
      end
      begin
        int wo = 0;
        @(negedge clk);
        while (!(br_cmd_en && cmd_en[0]) && wo < 100) begin @(negedge clk); wo++; end
        chk(br_cmd_en && cmd_en[0], "m0_write_cmd_seen", 64'(br_cmd_en), 64'(1));
        repeat (BC - 1) @(negedge clk);
        chk(busy[1], "m1_busy_last_beat", 64'(busy[1]), 64'(1));
        @(negedge clk);
`ifdef BURST_RAM_ARBITER_BACK_TO_BACK_EN
        chk(!busy[1], "b2b_grant", 64'(busy[1]), 64'(0));
`else
        chk(busy[1], "idle_gap", 64'(busy[1]), 64'(1));
        @(negedge clk);
        chk(!busy[1], "grant_after_gap", 64'(busy[1]), 64'(0));
`endif
      end
    join
    wait_drain();

    // Randomised mixed traffic, then read everything back through both masters
    fork
      random_master(0, 10);
      random_master(1, 10);
    join
    wait_drain();
    for (int i = 0; i < 4; i++) master_burst(i % 2, 1'b0, DW'(i * 4), '0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
